uart_loopback_checker: RTL
==========================

Name: uart_loopback_checker

Overview:
Parametrised UART link self-test engine. It drives a uart_tx-style transmitter with a generated data pattern and checks each frame returned by a uart_rx-style receiver on the far-end loopback. It counts frames, mismatches, parity errors and timeouts. Instantiated in board test tops between the UART pair and debug pins/LEDs; replaces ad-hoc per-top loopback state machines.

Parameters:
DATA_WIDTH, 8, frame payload width (1..16).
MODE, 0, pattern: 0 = incrementing from 0 mod 2^DATA_WIDTH; 1 = PRBS from 16-bit LFSR.
LFSR_SEED, 16'hACE1, LFSR reset/start value; must be nonzero.
NUM_FRAMES, 0, frames per run; 0 = run until enable drops.
GAP_CYCLES, 61, idle clocks between check and next frame start.
TIMEOUT_CYCLES, 4096, max clocks waiting for tx_busy rise or for rx_done.
CNT_WIDTH, 16, width of err_count and frame_count.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; high runs test, low stops after current frame
tx_data  out  DATA_WIDTH  payload to transmitter
start_tx  out  1  transmit request
tx_busy  in  1  transmitter busy
rx_data  in  DATA_WIDTH  receiver payload
rx_done  in  1  one-cycle receive strobe
parity_error  in  1  receiver parity flag, valid with rx_done
error_pulse  out  1  one-cycle pulse per mismatch or parity error
timeout_pulse  out  1  one-cycle pulse per timeout
err_count  out  CNT_WIDTH  total errors (mismatch + parity + timeout), saturating
frame_count  out  CNT_WIDTH  frames completed, wrapping
busy  out  1  high in every state except IDLE/DONE
done  out  1  high in DONE

Behaviour:
- Reset: all outputs 0; tx_data = pattern value 0 (MODE 0) or LFSR_SEED[DATA_WIDTH-1:0] (MODE 1); LFSR = LFSR_SEED; state IDLE; counters 0.
- States: IDLE, START, WAIT_TX, WAIT_RX, CHECK, GAP, DONE.
- IDLE: enable=1 -> clear err_count, frame_count, re-init pattern -> START.
- START: start_tx=1, tx_data stable. tx_busy=1 -> start_tx=0 next cycle, -> WAIT_TX. Timer reaches TIMEOUT_CYCLES first -> timeout, -> GAP.
- WAIT_TX: tx_busy=0 -> WAIT_RX, timer cleared.
- WAIT_RX: rx_done -> latch rx_data and parity_error, -> CHECK. Timer reaches TIMEOUT_CYCLES -> timeout, -> GAP.
- rx_done arriving in START/WAIT_TX is latched as well; WAIT_RX then moves to CHECK next cycle. Only the first rx_done per frame is used; later ones are ignored until next START.
- CHECK (1 cycle): error if latched data != tx_data or parity flag set. Error -> error_pulse=1 for that cycle only.
- Timeout -> timeout_pulse=1 for one cycle.
- Error or timeout -> err_count +1, saturating at all-ones.
- Every exit to GAP -> frame_count +1, wrapping.
- GAP: count GAP_CYCLES clocks, then advance pattern: MODE 0 tx_data+1 mod 2^DATA_WIDTH; MODE 1 LFSR shifts once, tx_data = LFSR[DATA_WIDTH-1:0].
- LFSR: Fibonacci, taps 16,14,13,11; fb = s[0]^s[2]^s[3]^s[5]; next = {fb, s[15:1]}.
- GAP exit: if NUM_FRAMES!=0 and frame_count==NUM_FRAMES -> DONE. Else if enable=0 -> IDLE. Else -> START.
- DONE: done=1, counters held; enable=0 -> IDLE.
- Error and timeout are mutually exclusive per frame.
- Reset mid-frame: immediate return to reset values; start_tx drops asynchronously.

Test Plan:
- MODE0, ideal loopback model, NUM_FRAMES=6: tx_data sequence 0x00..0x05. err_count=0, frame_count=6, done=1; start_tx drops the cycle after tx_busy rises.
- MODE0, loopback corrupts frame 3 (returns 0x13 for 0x03): exactly one error_pulse, in CHECK of frame 3; err_count=1; following frames continue from 0x04.
- parity_error=1 with correct data on frame 0 -> error_pulse once, err_count=1.
- rx_done never asserted, TIMEOUT_CYCLES=16: timeout_pulse exactly 16 clocks after WAIT_RX entry; err_count=1; next frame starts after GAP. Same with tx_busy stuck 0 -> timeout from START.
- MODE1, seed 0xACE1, DATA_WIDTH=8: first two frames 0xE1 then 0x70. CNT_WIDTH=2 with 5 forced errors -> err_count saturates at 3.
- Assert reset mid-WAIT_RX -> outputs 0 immediately. Drop enable mid-frame -> frame completes and returns to IDLE, done stays 0.

Source files
------------

// File: rtl/uart_loopback_checker.sv
// UART loopback self-test engine: sends a pattern through a tx/rx pair and
// scores every returned frame for mismatch, parity error or timeout.
module uart_loopback_checker #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          MODE           = 0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          NUM_FRAMES     = 0,
  parameter int          GAP_CYCLES     = 61,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_start_tx,
  input  logic                  i_tx_busy,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_parity_error,
  output logic                  o_error_pulse,
  output logic                  o_timeout_pulse,
  output logic [CNT_WIDTH-1:0]  o_err_count,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 2);
  localparam logic [TW-1:0] T_TMO = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_GAP = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] PAT0 = (MODE == 1) ? LFSR_SEED[DATA_WIDTH-1:0] : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_TX, S_WAIT_RX, S_CHECK, S_GAP, S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [TW-1:0]         r_timer;
  logic [15:0]           r_lfsr;
  logic [15:0]           w_lfsr_nxt;
  logic [DATA_WIDTH-1:0] r_pat;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_got;
  logic                  r_rx_par;
  logic                  w_tmo_hit;
  logic                  w_advance;
  logic                  w_to_gap;
  logic                  w_timed;

  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_tmo_hit  = (r_timer >= T_TMO);
  assign w_to_gap   = (w_next == S_GAP) && (r_state != S_GAP);
  assign w_timed    = (r_state == S_START) || (r_state == S_WAIT_RX) || (r_state == S_GAP);
  assign o_tx_data  = r_pat;
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done     = (r_state == S_DONE);

  // Receive/busy progress beats the timer, so error and timeout never coincide.
  always_comb begin
    w_next          = r_state;
    o_start_tx      = 1'b0;
    o_error_pulse   = 1'b0;
    o_timeout_pulse = 1'b0;
    w_advance       = 1'b0;
    case (r_state)
      S_IDLE:    if (i_enable) w_next = S_START;
      S_START: begin
        o_start_tx = 1'b1;
        if (i_tx_busy) w_next = S_WAIT_TX;
        else if (w_tmo_hit) begin
          o_timeout_pulse = 1'b1;
          w_next          = S_GAP;
        end
      end
      S_WAIT_TX: if (!i_tx_busy) w_next = S_WAIT_RX;
      S_WAIT_RX: begin
        if (r_rx_got || i_rx_done) w_next = S_CHECK;
        else if (w_tmo_hit) begin
          o_timeout_pulse = 1'b1;
          w_next          = S_GAP;
        end
      end
      S_CHECK: begin
        o_error_pulse = (r_rx_data != r_pat) || r_rx_par;
        w_next        = S_GAP;
      end
      S_GAP: begin
        if (r_timer == T_GAP) begin
          w_advance = 1'b1;
          if (NUM_FRAMES != 0 && o_frame_count == CNT_WIDTH'(NUM_FRAMES)) w_next = S_DONE;
          else if (!i_enable) w_next = S_IDLE;
          else w_next = S_START;
        end
      end
      S_DONE:    if (!i_enable) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_lfsr        <= LFSR_SEED;
      r_pat         <= PAT0;
      r_rx_data     <= '0;
      r_rx_got      <= 1'b0;
      r_rx_par      <= 1'b0;
      o_err_count   <= '0;
      o_frame_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_timed) r_timer <= '0;
      else                               r_timer <= r_timer + 1'b1;

      // First rx_done of a frame wins, even if it beats tx_busy falling.
      if (w_next == S_START && r_state != S_START) begin
        r_rx_got <= 1'b0;
        r_rx_par <= 1'b0;
      end else if (i_rx_done && !r_rx_got &&
                   (r_state == S_START || r_state == S_WAIT_TX || r_state == S_WAIT_RX)) begin
        r_rx_got  <= 1'b1;
        r_rx_data <= i_rx_data;
        r_rx_par  <= i_parity_error;
      end

      if (r_state == S_IDLE && i_enable) begin
        o_err_count   <= '0;
        o_frame_count <= '0;
        r_pat         <= PAT0;
        r_lfsr        <= LFSR_SEED;
      end else begin
        if (w_advance) begin
          r_lfsr <= w_lfsr_nxt;
          r_pat  <= (MODE == 1) ? w_lfsr_nxt[DATA_WIDTH-1:0] : r_pat + 1'b1;
        end
        if ((o_error_pulse || o_timeout_pulse) && !(&o_err_count))
          o_err_count <= o_err_count + 1'b1;
        if (w_to_gap) o_frame_count <= o_frame_count + 1'b1;
      end
    end
  end

endmodule
